// File: rtl/pw_conv_scheduler.sv
// Pointwise-conv group scheduler: splits each input word into GROUPS slices for the PW engine.
// Optional stall counter is enabled by defining PW_SCHED_STALL_CNT_EN.
module pw_conv_scheduler #(
    parameter int DATA_WIDTH   = 8,
    parameter int IN_CHANNEL   = 9,
    parameter int GROUPS       = 2,
    parameter int FRAME_PIXELS = 1024
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    start,
    input  logic                                    abort,
    input  logic                                    s_valid,
    output logic                                    s_ready,
    input  logic [DATA_WIDTH*IN_CHANNEL*GROUPS-1:0] s_data,
    output logic                                    m_valid,
    input  logic                                    m_ready,
    output logic [DATA_WIDTH*IN_CHANNEL-1:0]        m_data,
    output logic [$clog2(GROUPS)-1:0]               m_grp,
    output logic                                    m_first,
    output logic                                    m_last,
    output logic                                    busy,
    output logic                                    frame_done,
    output logic [15:0]                             stall_cnt
);

    localparam int W     = DATA_WIDTH * IN_CHANNEL;
    localparam int GRP_W = $clog2(GROUPS);
    localparam int PIX_W = $clog2(FRAME_PIXELS) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  next_state_s;
    logic [W*GROUPS-1:0]     hold_r;
    logic                    hold_v_r;
    logic [GRP_W-1:0]        grp_r;
    logic [PIX_W-1:0]        pix_cnt_r;

    logic                    last_grp_s;
    logic                    xfer_s;
    logic                    frame_end_s;
    logic                    accept_s;

    assign last_grp_s  = (grp_r == GRP_W'(GROUPS - 1));
    assign xfer_s      = (state_r == RUN) && hold_v_r && m_ready;
    assign frame_end_s = xfer_s && last_grp_s && (pix_cnt_r == PIX_W'(FRAME_PIXELS - 1));
    assign accept_s    = s_valid && s_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; abort overrides every other transition
    always_comb begin
        next_state_s = state_r;
        if (abort) begin
            next_state_s = IDLE;
        end else begin
            case (state_r)
                IDLE:    next_state_s = start ? RUN : IDLE;
                RUN:     next_state_s = frame_end_s ? DONE : RUN;
                DONE:    next_state_s = IDLE;
                default: next_state_s = IDLE;
            endcase
        end
    end

    // Output decode; s_ready refills the holding register in the same cycle its last group leaves
    always_comb begin
        s_ready    = 1'b0;
        m_valid    = 1'b0;
        m_data     = {W{1'b0}};
        m_grp      = grp_r;
        m_first    = 1'b0;
        m_last     = 1'b0;
        busy       = 1'b0;
        frame_done = 1'b0;
        case (state_r)
            IDLE: begin
                busy = 1'b0;
            end
            RUN: begin
                busy    = 1'b1;
                s_ready = (!hold_v_r || (m_ready && last_grp_s)) && !frame_end_s;
                m_valid = hold_v_r;
                if (hold_v_r) begin
                    m_data  = hold_r[grp_r*W +: W];
                    m_first = (grp_r == {GRP_W{1'b0}});
                    m_last  = last_grp_s;
                end else begin
                    m_data  = {W{1'b0}};
                end
            end
            DONE: begin
                busy       = 1'b1;
                frame_done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Holding register, group index and pixel counter
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_r    <= {(W*GROUPS){1'b0}};
            hold_v_r  <= 1'b0;
            grp_r     <= {GRP_W{1'b0}};
            pix_cnt_r <= {PIX_W{1'b0}};
        end else if (abort) begin
            hold_v_r  <= 1'b0;
            grp_r     <= {GRP_W{1'b0}};
            pix_cnt_r <= {PIX_W{1'b0}};
        end else if (state_r == IDLE) begin
            if (start) begin
                hold_v_r  <= 1'b0;
                grp_r     <= {GRP_W{1'b0}};
                pix_cnt_r <= {PIX_W{1'b0}};
            end
        end else if (state_r == RUN) begin
            if (accept_s) begin
                hold_r   <= s_data;
                hold_v_r <= 1'b1;
                grp_r    <= {GRP_W{1'b0}};
            end else if (xfer_s) begin
                if (last_grp_s) begin
                    hold_v_r <= 1'b0;
                    grp_r    <= {GRP_W{1'b0}};
                end else begin
                    grp_r    <= grp_r + GRP_W'(1);
                end
            end
            if (xfer_s && last_grp_s) begin
                pix_cnt_r <= pix_cnt_r + PIX_W'(1);
            end
        end
    end

`ifdef PW_SCHED_STALL_CNT_EN
    logic [15:0] stall_cnt_r;

    // Saturating count of cycles the PW engine holds off a valid group
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= 16'h0000;
        end else if ((state_r == IDLE) && start && !abort) begin
            stall_cnt_r <= 16'h0000;
        end else if ((state_r == RUN) && hold_v_r && !m_ready && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'h0001;
        end
    end

    assign stall_cnt = stall_cnt_r;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pw_conv_scheduler.sv
// Directed bench for pw_conv_scheduler: accepted words are expanded into expected groups
// in a scoreboard and checked as the PW side transfers them.
module tb_pw_conv_scheduler;

    localparam int DW = 8;
    localparam int IC = 9;
    localparam int G  = 2;
    localparam int FP = 4;
    localparam int W  = DW * IC;
    localparam int SW = W * G;

    logic          clk = 1'b0;
    logic          rst, start, abort, s_valid, s_ready, m_valid, m_ready;
    logic          m_first, m_last, busy, frame_done;
    logic [SW-1:0] s_data;
    logic [W-1:0]  m_data;
    logic [0:0]    m_grp;
    logic [15:0]   stall_cnt;

    typedef struct {
        logic [W-1:0] d;
        int           g;
    } exp_t;

    exp_t sb[$];
    int   pass_cnt = 0, total_cnt = 0;
    int   fd_cnt = 0, acc_cnt = 0, xfer_cnt = 0, gap_cnt = 0;
    int   cyc = 0, first_xfer_cyc = 0, last_xfer_cyc = 0, wcnt = 0;
    bit   gap_en = 1'b0;
    int   exp_stall;

    pw_conv_scheduler #(
        .DATA_WIDTH(DW), .IN_CHANNEL(IC), .GROUPS(G), .FRAME_PIXELS(FP)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_grp(m_grp),
        .m_first(m_first), .m_last(m_last), .busy(busy),
        .frame_done(frame_done), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [SW-1:0] mkword(input int n);
        logic [W-1:0] a, b;
        a = {9{8'hAA}} ^ W'(n);
        b = {9{8'hBB}} ^ W'(n << 4);
        return {b, a};
    endfunction

    // Scoreboard push on accept, pop/compare on transfer, frame_done bookkeeping
    always @(negedge clk) begin
        if (s_valid && s_ready) begin
            for (int g = 0; g < G; g++) begin
                exp_t e;
                e.d = s_data[g*W +: W];
                e.g = g;
                sb.push_back(e);
            end
            acc_cnt++;
        end
        if (m_valid && m_ready) begin
            chk("sb_nonempty", (sb.size() > 0) ? 1 : 0, 1);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("m_data", m_data, e.d);
                chk("m_grp", m_grp, e.g);
                chk("m_first", m_first, (e.g == 0) ? 1 : 0);
                chk("m_last", m_last, (e.g == G - 1) ? 1 : 0);
            end
            if (xfer_cnt == 0) first_xfer_cyc = cyc;
            last_xfer_cyc = cyc;
            xfer_cnt++;
        end
        if (frame_done) begin
            fd_cnt++;
            chk("fd_latency", cyc, last_xfer_cyc + 1);
        end
        if (gap_en && busy && !m_valid && !frame_done) gap_cnt++;
    end

    task automatic cyc_step();
        bit adv;
        @(negedge clk);
        adv = s_valid && s_ready;
        @(posedge clk);
        #1;
        if (adv) begin
            wcnt++;
            s_data = mkword(wcnt);
        end
    endtask

    task automatic wait_frame(input int target);
        for (int i = 0; i < 200 && fd_cnt < target; i++) cyc_step();
        chk("frame_done_seen", (fd_cnt >= target) ? 1 : 0, 1);
    endtask

    task automatic check_reset();
        @(negedge clk);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_grp", m_grp, 0);
        chk("rst_m_first", m_first, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
`ifdef PW_SCHED_STALL_CNT_EN
        exp_stall = 3;
`else
        exp_stall = 0;
`endif
        rst = 1'b1; start = 1'b0; abort = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        s_data = mkword(0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset();

        // Basic: continuous input and output
        @(posedge clk); #1;
        start = 1'b1; s_valid = 1'b1; m_ready = 1'b1;
        acc_cnt = 0; xfer_cnt = 0;
        cyc_step();
        start = 1'b0;
        @(negedge clk);
        chk("start_busy", busy, 1);
        chk("start_s_ready", s_ready, 1);
        wait_frame(1);
        chk("basic_xfers", xfer_cnt, 8);
        chk("basic_accepts", acc_cnt, 4);
        chk("basic_no_bubble", last_xfer_cyc - first_xfer_cyc, 7);
        repeat (5) cyc_step();
        chk("basic_no_extra_accept", acc_cnt, 4);
        chk("basic_idle", busy, 0);
        chk("basic_fd_once", fd_cnt, 1);
        chk("basic_sb_empty", sb.size(), 0);

        // Backpressure on group 1
        start = 1'b1; m_ready = 1'b0; s_valid = 1'b1;
        acc_cnt = 0; xfer_cnt = 0;
        cyc_step();
        start = 1'b0;
        cyc_step();
        chk("bp_m_valid", m_valid, 1);
        chk("bp_grp0", m_grp, 0);
        m_ready = 1'b1;
        cyc_step();
        m_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("bp_data_stable", m_data, (sb.size() > 0) ? sb[0].d : {W{1'bx}});
            chk("bp_grp1", m_grp, 1);
            chk("bp_s_ready", s_ready, 0);
            @(posedge clk); #1;
        end
        chk("bp_stall_cnt", stall_cnt, exp_stall);
        m_ready = 1'b1;
        wait_frame(2);
        chk("bp_xfers", xfer_cnt, 8);
        chk("bp_stall_final", stall_cnt, exp_stall);

        // Input gaps: one valid word every third cycle
        cyc_step();
        start = 1'b1; s_valid = 1'b0; m_ready = 1'b1;
        acc_cnt = 0; xfer_cnt = 0; gap_cnt = 0;
        cyc_step();
        start = 1'b0;
        gap_en = 1'b1;
        for (int p = 0; p < FP; p++) begin
            s_valid = 1'b1;
            cyc_step();
            s_valid = 1'b0;
            cyc_step();
            cyc_step();
        end
        wait_frame(3);
        gap_en = 1'b0;
        chk("gap_count", gap_cnt, 4);
        chk("gap_accepts", acc_cnt, 4);
        repeat (3) cyc_step();
        chk("gap_fd_once", fd_cnt, 3);

        // Abort mid-group of the third pixel
        start = 1'b1; s_valid = 1'b1; m_ready = 1'b1;
        cyc_step();
        start = 1'b0;
        repeat (6) cyc_step();
        abort = 1'b1;
        cyc_step();
        abort = 1'b0; s_valid = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_m_valid", m_valid, 0);
        chk("abort_s_ready", s_ready, 0);
        repeat (3) cyc_step();
        chk("abort_no_fd", fd_cnt, 3);
        sb.delete();

        // Full frame after abort
        acc_cnt = 0; xfer_cnt = 0;
        start = 1'b1; s_valid = 1'b1;
        cyc_step();
        start = 1'b0;
        wait_frame(4);
        chk("restart_accepts", acc_cnt, 4);
        chk("restart_xfers", xfer_cnt, 8);

        // Start ignored in RUN, then reset with a word held
        cyc_step();
        start = 1'b1; s_valid = 1'b1; m_ready = 1'b0;
        cyc_step();
        start = 1'b0;
        cyc_step();
        chk("hold_m_valid", m_valid, 1);
        start = 1'b1;
        cyc_step();
        start = 1'b0;
        @(negedge clk);
        chk("run_start_busy", busy, 1);
        chk("run_start_grp", m_grp, 0);
        chk("run_start_valid", m_valid, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        cyc_step();
        rst = 1'b0; s_valid = 1'b0;
        check_reset();
        sb.delete();

        // Start and abort together in IDLE
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1;
        cyc_step();
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("start_abort_idle", busy, 0);
        chk("start_abort_s_ready", s_ready, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
